// File: rtl/ahb_if_pkg.sv
// ---------------------------------------------------------------------------
// ahb_if_pkg
// Shared AHB5 bus types for the ahb5_if interface family: transfer type,
// transfer size and response encodings, plus helpers used by responders.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_if_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } transfer_type_e;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_4WORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } size_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_e;

  // Upper bound on the programmable number of data-phase wait states.
  localparam int MAX_WAIT_STATES = 15;

  // Number of bytes moved by one beat of the given size.
  function automatic int unsigned size_bytes(size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahb5_excl_monitor.sv
// ---------------------------------------------------------------------------
// ahb5_excl_monitor
// Single-entry exclusive-access monitor. Remembers which manager last made an
// exclusive read and of which memory word, and judges exclusive writes.
// Ports:
//   hclk, hreset  clock and synchronous active-high reset (entry invalid)
//   set           load entry with {id, word} (legal exclusive read completes)
//   clear_match   invalidate entry if it holds 'word' (a write committed)
//   check         an exclusive write is being judged this cycle
//   id, word      manager id and word index of the current data phase
//   pass          check & entry valid & id and word both match
// ---------------------------------------------------------------------------
module ahb5_excl_monitor #(
  parameter int ID_WIDTH   = 8,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  set,
  input  logic                  clear_match,
  input  logic                  check,
  input  logic [ID_WIDTH-1:0]   id,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  pass
);

  logic                  valid;
  logic [ID_WIDTH-1:0]   entry_id;
  logic [WORD_WIDTH-1:0] entry_word;

  assign pass = check & valid & (entry_id == id) & (entry_word == word);

  // A new exclusive read always replaces the entry; any committed write to the
  // monitored word (including a passing exclusive write) retires it.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      valid      <= 1'b0;
      entry_id   <= '0;
      entry_word <= '0;
    end else if (set) begin
      valid      <= 1'b1;
      entry_id   <= id;
      entry_word <= word;
    end else if (clear_match && valid && (entry_word == word)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb5_sram_subordinate.sv
// ---------------------------------------------------------------------------
// ahb5_sram_subordinate
// AHB5 subordinate backed by a register-array memory. Supports programmable
// wait states, two-cycle ERROR responses for illegal transfers and a single
// exclusive-access monitor reported through hexokay.
// Ports:
//   hclk, hreset              clock, synchronous active-high reset
//   hsel, haddr, htrans,      address-phase controls, sampled when
//   hsize, hwrite, hexcl,     hsel & hready & (NONSEQ | SEQ)
//   hmaster, hready
//   hwdata, hwstrb            write data and byte strobes (data phase)
//   hreadyout, hresp          data-phase handshake and response
//   hrdata                    read data, valid only in a read completion cycle
//   hexokay                   exclusive success, only in completion cycles
// ---------------------------------------------------------------------------
module ahb5_sram_subordinate
  import ahb_if_pkg::*;
#(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int HMASTER_WIDTH = 8,
  parameter  int MEM_DEPTH     = 256,
  parameter  int WAIT_STATES   = 0,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic                     hsel,
  input  logic [ADDR_WIDTH-1:0]    haddr,
  input  transfer_type_e           htrans,
  input  size_e                    hsize,
  input  logic                     hwrite,
  input  logic                     hexcl,
  input  logic [HMASTER_WIDTH-1:0] hmaster,
  input  logic [DATA_WIDTH-1:0]    hwdata,
  input  logic [STRB_WIDTH-1:0]    hwstrb,
  input  logic                     hready,
  output logic                     hreadyout,
  output resp_e                    hresp,
  output logic [DATA_WIDTH-1:0]    hrdata,
  output logic                     hexokay
);

  localparam int         OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam int         WORD_BITS   = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE    = 3'(OFFSET_BITS);
  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                   state;
  logic [3:0]               wait_cnt;
  logic                     dp_valid;
  logic                     dp_write;
  logic                     dp_excl;
  logic [HMASTER_WIDTH-1:0] dp_master;
  logic [WORD_BITS-1:0]     dp_word;
  logic [OFFSET_BITS-1:0]   dp_offset;
  size_e                    dp_size;

  logic                   accept;
  logic                   addr_err;
  logic                   size_err;
  logic                   align_err;
  logic                   req_err;
  logic [OFFSET_BITS-1:0] align_mask;
  logic                   complete;
  logic                   excl_pass;
  logic                   commit;
  logic [STRB_WIDTH-1:0]  lane_en;

  // Only take a new address phase while we are ourselves ready, so a
  // mis-wired hready can never overwrite a data phase still in progress.
  assign accept = hsel & hready & hreadyout &
                  ((htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ));

  // Any address bit above the memory window makes the access out of range.
  assign addr_err   = (haddr >> (WORD_BITS + OFFSET_BITS)) != '0;
  assign size_err   = hsize > MAX_SIZE;
  assign align_mask = OFFSET_BITS'(size_bytes(hsize) - 32'd1);
  assign align_err  = |(haddr[OFFSET_BITS-1:0] & align_mask);
  assign req_err    = addr_err | size_err | align_err;

  // A legal data phase completes in the first IDLE cycle after acceptance
  // (immediately for zero wait states, after the WAIT countdown otherwise).
  assign complete = (state == ST_IDLE) & dp_valid;
  assign commit   = complete & dp_write & (~dp_excl | excl_pass);

  // Strobes only reach lanes covered by the transfer's size/offset window.
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      lane_en[i] = hwstrb[i] &&
                   (i >= int'(dp_offset)) &&
                   (i < int'(dp_offset) + int'(size_bytes(dp_size)));
    end
  end

  ahb5_excl_monitor #(
    .ID_WIDTH   (HMASTER_WIDTH),
    .WORD_WIDTH (WORD_BITS)
  ) u_excl_monitor (
    .hclk        (hclk),
    .hreset      (hreset),
    .set         (complete & ~dp_write & dp_excl),
    .clear_match (commit),
    .check       (complete & dp_write & dp_excl),
    .id          (dp_master),
    .word        (dp_word),
    .pass        (excl_pass)
  );

  // Control FSM: tracks the data phase of the last accepted transfer. ERR2 and
  // a completing IDLE cycle both allow a pipelined address phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_excl   <= 1'b0;
      dp_master <= '0;
      dp_word   <= '0;
      dp_offset <= '0;
      dp_size   <= SIZE_BYTE;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            dp_write  <= hwrite;
            dp_excl   <= hexcl;
            dp_master <= hmaster;
            dp_word   <= haddr[OFFSET_BITS +: WORD_BITS];
            dp_offset <= haddr[OFFSET_BITS-1:0];
            dp_size   <= hsize;
            if (req_err) begin
              dp_valid <= 1'b0;
              state    <= ST_ERR1;
            end else begin
              dp_valid <= 1'b1;
              if (WAIT_STATES == 0) begin
                state <= ST_IDLE;
              end else begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_LOAD;
              end
            end
          end else begin
            dp_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_IDLE;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory is not reset; a write is suppressed if reset lands on its edge.
  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (lane_en[i]) begin
          mem[dp_word][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Outputs decode directly from registered state so they never depend on
  // same-cycle address-phase inputs.
  always_comb begin
    hreadyout = (state == ST_IDLE) || (state == ST_ERR2);
    hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    hrdata    = (complete && !dp_write) ? mem[dp_word] : '0;
    hexokay   = complete & dp_excl & (dp_write ? excl_pass : 1'b1);
  end

endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// ---------------------------------------------------------------------------
// tb_ahb5_sram_subordinate
// Two instances share one driver: inst 0 with no wait states, inst 1 with
// WS1 wait states. dut_sel routes hsel and observation to one instance.
// A byte-level reference memory plus a single exclusive entry per instance
// predicts each response at issue time; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ahb5_sram_subordinate;
  import ahb_if_pkg::*;

  localparam int WS1 = 3;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic           hsel;
  logic [31:0]    haddr;
  transfer_type_e htrans;
  size_e          hsize;
  logic           hwrite;
  logic           hexcl;
  logic [7:0]     hmaster;
  logic [31:0]    hwdata;
  logic [3:0]     hwstrb;
  logic           dut_sel;

  logic        ro0, ro1, xo0, xo1;
  resp_e       resp0, resp1;
  logic [31:0] rd0, rd1;

  logic        obs_ro, obs_xo;
  resp_e       obs_resp;
  logic [31:0] obs_rd;

  assign obs_ro   = dut_sel ? ro1   : ro0;
  assign obs_xo   = dut_sel ? xo1   : xo0;
  assign obs_resp = dut_sel ? resp1 : resp0;
  assign obs_rd   = dut_sel ? rd1   : rd0;

  ahb5_sram_subordinate #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & ~dut_sel), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hexcl(hexcl),
    .hmaster(hmaster), .hwdata(hwdata), .hwstrb(hwstrb), .hready(ro0),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0), .hexokay(xo0)
  );

  ahb5_sram_subordinate #(.WAIT_STATES(WS1)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & dut_sel), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hexcl(hexcl),
    .hmaster(hmaster), .hwdata(hwdata), .hwstrb(hwstrb), .hready(ro1),
    .hreadyout(ro1), .hresp(resp1), .hrdata(rd1), .hexokay(xo1)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        exokay;
    int          waits;
  } exp_t;

  exp_t       scb[$];
  logic [7:0] ref_mem [2][1024];
  logic       mon_valid [2];
  logic [7:0] mon_id [2];
  int         mon_word [2];
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: bytes in range, size within a word, naturally
  // aligned; exclusive writes succeed only against the matching entry.
  task automatic modelTransfer(input int d, input logic wr, input logic [31:0] addr,
                               input int sz, input logic [31:0] wdata, input logic [3:0] strb,
                               input logic excl, input logic [7:0] mid, output exp_t e);
    int  nb;
    int  word;
    int  lane;
    logic ok;
    nb       = 1 << sz;
    word     = int'(addr / 4);
    e.err    = (addr >= 32'd1024) || (sz > 2) || ((addr % nb) != 0);
    e.rdata  = '0;
    e.exokay = 1'b0;
    e.waits  = (d == 1) ? WS1 : 0;
    if (e.err) return;
    if (wr) begin
      ok = !excl || (mon_valid[d] && mon_id[d] == mid && mon_word[d] == word);
      if (ok) begin
        for (int b = 0; b < nb; b++) begin
          lane = (int'(addr) + b) % 4;
          if (strb[lane]) ref_mem[d][int'(addr) + b] = wdata[8*lane +: 8];
        end
        if (mon_valid[d] && mon_word[d] == word) mon_valid[d] = 1'b0;
      end
      e.exokay = excl && ok;
    end else begin
      for (int b = 0; b < 4; b++) e.rdata[8*b +: 8] = ref_mem[d][word*4 + b];
      if (excl) begin
        mon_valid[d] = 1'b1;
        mon_id[d]    = mid;
        mon_word[d]  = word;
        e.exokay     = 1'b1;
      end
    end
  endtask

  // Presents one address phase (called at posedge+1), holds it until
  // accepted, then drives its write data for the following data phase.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input int sz,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic excl, input logic [7:0] mid, input logic abort);
    exp_t e;
    int   guard;
    hsel    = 1'b1;
    haddr   = addr;
    htrans  = ($urandom_range(0, 3) == 0) ? TRANS_SEQ : TRANS_NONSEQ;
    hsize   = size_e'(sz);
    hwrite  = wr;
    hexcl   = excl;
    hmaster = mid;
    guard   = 0;
    do begin
      @(negedge hclk);
      guard++;
    end while (!obs_ro && guard < 50);
    checkOutput("accept_timeout", {31'b0, obs_ro}, 32'd1);
    if (!abort) begin
      modelTransfer(int'(dut_sel), wr, addr, sz, wdata, strb, excl, mid, e);
      scb.push_back(e);
    end
    @(posedge hclk);
    #1;
    hwdata = wdata;
    hwstrb = strb;
    hsel   = 1'b0;
    htrans = TRANS_IDLE;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      hsel   = 1'($urandom_range(0, 1));
      htrans = ($urandom_range(0, 1) == 1) ? TRANS_BUSY : TRANS_IDLE;
      haddr  = $urandom;
      @(posedge hclk);
      #1;
    end
    hsel   = 1'b0;
    htrans = TRANS_IDLE;
  endtask

  task automatic randomTransfer();
    logic [31:0] addr;
    int          sz;
    logic        excl;
    logic [7:0]  mid;
    int          r;
    r    = $urandom_range(0, 99);
    sz   = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
    excl = ($urandom_range(0, 9) < 3);
    case ($urandom_range(0, 2))
      0:       mid = 8'd3;
      1:       mid = 8'd5;
      default: mid = 8'd7;
    endcase
    if (r < 8) begin
      addr = $urandom_range(1024, 32'h0000_FFFF);
    end else begin
      addr = excl ? $urandom_range(0, 31) : $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
    end
    applyStimulus(1'($urandom_range(0, 1)), addr, sz, $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
                  excl, mid, 1'b0);
    if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
  endtask

  // Monitor: follows each data phase of the observed instance, counting
  // wait cycles and comparing the completion against the queued prediction.
  logic mon_active = 1'b0;
  int   wait_seen = 0;
  always @(negedge hclk) begin
    exp_t e;
    if (hreset) begin
      scb.delete();
      mon_active = 1'b0;
      wait_seen  = 0;
    end else begin
      if (mon_active) begin
        if (scb.size() == 0) begin
          checkOutput("scb_empty", 32'd1, 32'd0);
          mon_active = 1'b0;
        end else if (!obs_ro) begin
          wait_seen++;
          checkOutput("wait_hresp", {31'b0, obs_resp}, scb[0].err ? 32'd1 : 32'd0);
          checkOutput("wait_hexokay", {31'b0, obs_xo}, 32'd0);
          checkOutput("wait_hrdata", obs_rd, 32'd0);
          if (wait_seen > 20) begin
            checkOutput("wait_bound", wait_seen, 32'd20);
            void'(scb.pop_front());
            mon_active = 1'b0;
          end
        end else begin
          e = scb.pop_front();
          checkOutput("wait_count", wait_seen, e.err ? 32'd1 : e.waits);
          checkOutput("hresp", {31'b0, obs_resp}, e.err ? 32'd1 : 32'd0);
          checkOutput("hrdata", obs_rd, e.rdata);
          checkOutput("hexokay", {31'b0, obs_xo}, {31'b0, e.exokay});
          mon_active = 1'b0;
        end
      end else begin
        checkOutput("idle_hreadyout", {31'b0, obs_ro}, 32'd1);
        checkOutput("idle_hresp", {31'b0, obs_resp}, 32'd0);
        checkOutput("idle_hrdata", obs_rd, 32'd0);
        checkOutput("idle_hexokay", {31'b0, obs_xo}, 32'd0);
      end
      if (hsel && obs_ro && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ)) begin
        mon_active = 1'b1;
        wait_seen  = 0;
      end
    end
  end

  initial begin
    dut_sel = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = TRANS_IDLE;
    hsize   = SIZE_WORD;
    hwrite  = 1'b0;
    hexcl   = 1'b0;
    hmaster = '0;
    hwdata  = '0;
    hwstrb  = '0;
    for (int d = 0; d < 2; d++) begin
      mon_valid[d] = 1'b0;
      mon_id[d]    = '0;
      mon_word[d]  = 0;
    end
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;

    // Give both memories known contents in the tested region.
    for (int d = 0; d < 2; d++) begin
      dut_sel = 1'(d);
      for (int w = 0; w < 64; w++) applyStimulus(1'b1, 32'(w * 4), 2, $urandom, 4'hF, 1'b0, 8'd1, 1'b0);
      idleCycles(WS1 + 3);
    end
    dut_sel = 1'b0;

    $display("[TB] directed sequences, zero wait states");
    applyStimulus(1'b1, 32'h10, 2, 32'hDEADBEEF, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h10, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h400, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 32'h2, 2, 32'h12345678, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h0, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 32'h4, 2, 32'h11223344, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 32'h5, 0, 32'h0000AA00, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h4, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h20, 2, 32'h0, 4'hF, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 32'h20, 2, 32'hCAFE0001, 4'hF, 1'b0, 8'd5, 1'b0);
    applyStimulus(1'b1, 32'h20, 2, 32'h33333333, 4'hF, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 32'h20, 2, 32'h0, 4'hF, 1'b0, 8'd3, 1'b0);
    applyStimulus(1'b0, 32'h20, 2, 32'h0, 4'hF, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 32'h20, 2, 32'h44444444, 4'hF, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 32'h20, 2, 32'h0, 4'hF, 1'b0, 8'd3, 1'b0);
    idleCycles(2);

    $display("[TB] random traffic, zero wait states");
    for (int n = 0; n < 300; n++) randomTransfer();
    idleCycles(WS1 + 3);

    dut_sel = 1'b1;
    $display("[TB] directed sequences, %0d wait states", WS1);
    applyStimulus(1'b0, 32'h0, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h4, 2, 32'h0, 4'hF, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 32'h40, 2, 32'h0, 4'hF, 1'b1, 8'd3, 1'b0);
    // Write accepted, then reset lands while it is still waiting.
    applyStimulus(1'b1, 32'h40, 2, 32'hBADBAD00, 4'hF, 1'b0, 8'd5, 1'b1);
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_valid[0] = 1'b0;
    mon_valid[1] = 1'b0;
    applyStimulus(1'b1, 32'h40, 2, 32'h55555555, 4'hF, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 32'h40, 2, 32'h0, 4'hF, 1'b0, 8'd3, 1'b0);
    applyStimulus(1'b0, 32'h401, 2, 32'h0, 4'hF, 1'b0, 8'd3, 1'b0);
    idleCycles(2);

    $display("[TB] random traffic, %0d wait states", WS1);
    for (int n = 0; n < 150; n++) randomTransfer();
    idleCycles(WS1 + 4);

    checkOutput("scb_drained", scb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
